// File: rtl/if_pkg.sv
// Shared fetch front-end types: instruction width, PC increment and fetch FSM states.
// Pure declarations; no timing or flow control of its own.
package if_pkg;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries; a push is visible at the head one cycle later.
// The writer must hold off when full (caller tracks credit); flush empties it and voids push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && valid;
  // Head is forced to zero when empty so stale entries never leak onto the output.
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push && !do_pop) assert (count < CNT_W'(DEPTH));
  end
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: sequential PCs, one outstanding imem request, queued {pc, inst} to decode.
// Head valid one cycle after the response; requests stop when queue plus in-flight would exceed DEPTH.
module if_fetch_queue import if_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t             state;
  logic                     run;
  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        req_pc;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           in_use;
  logic                     credit_ok;
  logic                     grant;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+INST_W-1:0] head;

  // An outstanding request already owns a queue slot, so it counts against credit.
  assign in_use    = {1'b0, count} + {{CNT_W{1'b0}}, (state != IDLE)};
  assign credit_ok = in_use < (CNT_W + 1)'(DEPTH);
  assign imem_req  = run && (state == IDLE) && credit_ok && !redirect;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign push      = (state == WAIT) && imem_rvalid && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
  assign {out_pc, out_inst} = head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      state  <= IDLE;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        pc <= redirect_pc & ~ADDR_W'(3);
        // A response still owed to the old stream must be swallowed when it arrives.
        if (state != IDLE) state <= imem_rvalid ? IDLE : DROP;
      end else begin
        case (state)
          IDLE: begin
            if (grant) begin
              req_pc <= pc;
              pc     <= pc + ADDR_W'(PC_STEP);
              state  <= WAIT;
            end
          end
          WAIT, DROP: begin
            if (imem_rvalid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({req_pc, imem_rdata}),
    .rdata (head),
    .valid (out_valid),
    .count (count)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus a randomized run against a PC-stream model.
module tb_if_fetch_queue;
  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int mem_lat  = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t pend[$];

  logic        o_req, o_gnt, o_pop, o_valid;
  logic [31:0] o_addr, o_pc, o_inst;

  if_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Sample the settled cycle and let the memory model log any grant.
  task automatic settle();
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_gnt   = imem_req && imem_gnt;
    o_pop   = out_valid && out_ready && !redirect;
    o_valid = out_valid;
    o_pc    = out_pc;
    o_inst  = out_inst;
    if (o_gnt) pend.push_back('{imem_addr, cyc_n + mem_lat});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc_n++;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0; mem_lat = 1;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn  = 1'b1;
    cyc_n = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
    #1 rstn = 1'b0;
    #3;
    checks++; if (imem_req !== 1'b0)  begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0)   begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
    do_reset();
    imem_gnt = 1'b1;
    settle();
    checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL release_req_early got=%b exp=0", o_req); end
    advance();
    settle();
    checks++; if (o_req !== 1'b1 || o_addr !== RESET_PC)
      begin failures++; $display("FAIL first_req got=%b/%h exp=1/%h", o_req, o_addr, RESET_PC); end
    advance();
  endtask

  task automatic test_sequential();
    int npop = 0;
    int first_gnt = -1;
    int last_pop = -1;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1; mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (o_gnt && first_gnt < 0) first_gnt = cyc_n;
      if (o_pop && npop < 3) begin
        checks++; if (o_pc !== 32'(npop * 4))
          begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", npop, o_pc, 32'(npop * 4)); end
        checks++; if (o_inst !== inst_of(32'(npop * 4)))
          begin failures++; $display("FAIL seq_inst%0d got=%h exp=%h", npop, o_inst, inst_of(32'(npop * 4))); end
        if (npop == 0) begin
          checks++; if (cyc_n !== first_gnt + 2)
            begin failures++; $display("FAIL seq_first_latency got=%0d exp=%0d", cyc_n, first_gnt + 2); end
        end else begin
          checks++; if (cyc_n - last_pop !== 2)
            begin failures++; $display("FAIL seq_interval got=%0d exp=2", cyc_n - last_pop); end
        end
        last_pop = cyc_n;
        npop++;
      end
      advance();
    end
    checks++; if (npop < 3) begin failures++; $display("FAIL seq_count got=%0d exp>=3", npop); end
  endtask

  task automatic test_backpressure();
    int ngnt = 0;
    logic found = 1'b0;
    logic [31:0] addr = '0;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b0; mem_lat = 1;
    for (int i = 0; i < 24; i++) begin
      settle();
      if (o_gnt) ngnt++;
      advance();
    end
    settle();
    checks++; if (ngnt !== DEPTH) begin failures++; $display("FAIL bp_grants got=%0d exp=%0d", ngnt, DEPTH); end
    checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%b exp=0", o_req); end
    out_ready = 1'b1;
    settle();
    checks++; if (o_pop !== 1'b1 || o_pc !== 32'h0)
      begin failures++; $display("FAIL bp_first_pop got=%b/%h exp=1/00000000", o_pop, o_pc); end
    advance();
    for (int i = 0; i < 6 && !found; i++) begin
      settle();
      if (o_gnt) begin found = 1'b1; addr = o_addr; end
      advance();
    end
    checks++; if (!found || addr !== 32'h10)
      begin failures++; $display("FAIL bp_resume got=%b/%h exp=1/00000010", found, addr); end
  endtask

  task automatic test_redirect_wait();
    logic found = 1'b0;
    logic [31:0] pc = '0;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1; mem_lat = 2;
    settle(); advance();
    settle();
    checks++; if (o_gnt !== 1'b1 || o_addr !== 32'h0)
      begin failures++; $display("FAIL rw_grant got=%b/%h exp=1/00000000", o_gnt, o_addr); end
    advance();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL rw_req_on_redirect got=%b exp=0", o_req); end
    advance();
    settle();
    checks++; if (o_valid !== 1'b0 || o_req !== 1'b0)
      begin failures++; $display("FAIL rw_drop_cycle got=%b/%b exp=0/0", o_valid, o_req); end
    advance();
    settle();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rw_queue_empty got=%b exp=0", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h100)
      begin failures++; $display("FAIL rw_new_addr got=%b/%h exp=1/00000100", o_req, o_addr); end
    advance();
    for (int i = 0; i < 8 && !found; i++) begin
      settle();
      if (o_pop) begin found = 1'b1; pc = o_pc; end
      advance();
    end
    checks++; if (!found || pc !== 32'h100)
      begin failures++; $display("FAIL rw_first_out got=%b/%h exp=1/00000100", found, pc); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1; mem_lat = 1;
    settle(); advance();
    settle(); advance();
    checks++; if (imem_rvalid !== 1'b1) begin failures++; $display("FAIL rr_rvalid_setup got=%b exp=1", imem_rvalid); end
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    settle(); advance();
    settle();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rr_discard got=%b exp=0", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h2000)
      begin failures++; $display("FAIL rr_new_addr got=%b/%h exp=1/00002000", o_req, o_addr); end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1; mem_lat = 1;
    settle(); advance();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    settle(); advance();
    settle();
    checks++; if (o_gnt !== 1'b1 || o_addr !== 32'hFFFF_FFFC)
      begin failures++; $display("FAIL wrap_grant got=%b/%h exp=1/fffffffc", o_gnt, o_addr); end
    advance();
    settle(); advance();
    settle();
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h0)
      begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", o_req, o_addr); end
    checks++; if (o_pop !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_inst !== inst_of(32'hFFFF_FFFC))
      begin failures++; $display("FAIL wrap_out got=%b/%h/%h exp=1/fffffffc/%h", o_pop, o_pc, o_inst, inst_of(32'hFFFF_FFFC)); end
    advance();
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    logic [31:0] pc = '0;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b0; mem_lat = 3;
    for (int i = 0; i < 10; i++) begin settle(); advance(); end
    settle();
    checks++; if (o_valid !== 1'b1 || o_req !== 1'b0)
      begin failures++; $display("FAIL rm_setup got=%b/%b exp=1/0", o_valid, o_req); end
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0)
      begin failures++; $display("FAIL rm_immediate got=%b/%b exp=0/0", out_valid, imem_req); end
    @(posedge clk);
    #1;
    rstn = 1'b1; cyc_n = 0; pend.delete();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle(); advance();
    mem_lat = 1; out_ready = 1'b1;
    settle();
    checks++; if (o_req !== 1'b1 || o_addr !== RESET_PC || o_valid !== 1'b0)
      begin failures++; $display("FAIL rm_restart got=%b/%h/%b exp=1/%h/0", o_req, o_addr, o_valid, RESET_PC); end
    advance();
    for (int i = 0; i < 8 && !found; i++) begin
      settle();
      if (o_pop) begin found = 1'b1; pc = o_pc; end
      advance();
    end
    checks++; if (!found || pc !== RESET_PC)
      begin failures++; $display("FAIL rm_first_out got=%b/%h exp=1/%h", found, pc, RESET_PC); end
  endtask

  // Model: requests and outputs each follow a +4 PC stream that restarts at every redirect target.
  task automatic test_random();
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] exp_out = RESET_PC;
    int npop = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_gnt    = ($urandom % 4) != 0;
      out_ready   = ($urandom % 3) != 0;
      redirect    = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      mem_lat     = $urandom_range(1, 3);
      settle();
      if (o_gnt) begin
        checks++; if (o_addr !== exp_req)
          begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc_n, o_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (o_pop) begin
        checks++; if (o_pc !== exp_out || o_inst !== inst_of(exp_out))
          begin failures++; $display("FAIL rnd_out cyc=%0d got=%h/%h exp=%h/%h", cyc_n, o_pc, o_inst, exp_out, inst_of(exp_out)); end
        exp_out = exp_out + 32'd4;
        npop++;
      end
      if (redirect) begin
        exp_req = {redirect_pc[31:2], 2'b00};
        exp_out = {redirect_pc[31:2], 2'b00};
      end
      advance();
    end
    checks++; if (npop < 300) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=300", npop); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction fetch front end for the cqu_mips five-stage pipeline. It replaces the single-register PC stage: it generates sequential PCs, issues one instruction-memory request at a time over a request/grant + response handshake, buffers returned instructions with their PCs in a DEPTH-entry queue, and hands them to decode over valid/ready. Redirects (jump/branch) flush the queue and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- DEPTH, 4, queue entries; power of two, ≥ 2
- ADDR_W, 32, PC / address width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- redirect  in  1  jump/branch taken; highest priority
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address (current PC)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid (≥1 cycle after grant)
- imem_rdata  in  32  fetched instruction
- out_valid  out  1  queue head valid to decode
- out_pc  out  ADDR_W  PC of head entry
- out_inst  out  32  instruction of head entry
- out_ready  in  1  decode accepts head; pop when out_valid && out_ready

## Operation
- Registers: pc, req_pc, run flag, FSM state, queue.
- FSM: IDLE (nothing outstanding), WAIT (response pending, keep), DROP (response pending, discard).
- credit_ok = (queue count + outstanding) < DEPTH; outstanding = state≠IDLE.
- imem_req = run && state==IDLE && credit_ok && !redirect; imem_addr = pc.
- Grant (IDLE): req_pc ← pc, pc ← pc + 4 (wraps mod 2^ADDR_W), → WAIT.
- WAIT + rvalid: push {req_pc, imem_rdata}, → IDLE.
- DROP + rvalid: discard, → IDLE.
- Redirect: pc ← {redirect_pc[ADDR_W-1:2],2'b00}; queue flushed; WAIT without rvalid → DROP; WAIT/DROP with rvalid → IDLE, data discarded; IDLE stays IDLE. Pop and push in a redirect cycle are void.
- Push + pop same cycle: count unchanged; push when empty with out_ready high still takes one cycle to appear.
- Credit guarantees no push when full; overflow impossible by construction (assert in sim).
- rvalid in IDLE is a protocol error: ignored.

## Timing
- Reset (async, rstn low): pc=RESET_PC, req_pc=RESET_PC, state=IDLE, run=0, queue empty; imem_req=0, out_valid=0, out_pc=0, out_inst=0.
- run sets on first clk edge after rstn release; imem_req first asserts that cycle with imem_addr=RESET_PC.
- imem_req/imem_addr combinational from registers and redirect; no combinational path from imem_gnt/imem_rvalid to imem_req.
- Response to out_valid: 1 cycle (registered queue). Minimum fetch throughput: one instruction per 2 cycles with 1-cycle memory latency.
- Redirect to first request at new PC: next cycle.
- Reset mid-operation: all state cleared immediately; late responses after release in IDLE are ignored.

## Structure
- Shared package if_pkg: INST_W=32, PC_STEP=4, fetch state enum {IDLE, WAIT, DROP}.
- One sub-module: fetch_fifo (synchronous FIFO, params DEPTH and WIDTH=ADDR_W+INST_W, push/pop/flush, count output, read-pointer wrap at DEPTH). PC/FSM logic in top.

## Test plan
- Reset release, gnt=1, rvalid one cycle after grant, out_ready=1 → out_pc sequence 0x0,0x4,0x8 with matching imem_rdata, one every 2 cycles.
- out_ready=0, DEPTH=4 → exactly 4 grants, then imem_req stays 0; raising out_ready pops 0x0 first and requests resume.
- Redirect to 0x0000_0103 while WAIT, rvalid next cycle → that response dropped, queue empty, next imem_addr=0x0000_0100.
- Redirect in same cycle as rvalid → data discarded, state IDLE, next request at redirect target.
- pc=0xFFFF_FFFC granted (ADDR_W=32) → next imem_addr=0x0000_0000.
- rstn low mid-WAIT with 2 entries queued → out_valid=0, imem_req=0 immediately; after release first imem_addr=RESET_PC.
